// File: rtl/demux_strobe_pkg.sv
// rtl/demux_strobe_pkg.sv - shared types and constants for the decoder strobe arbiter
// Purpose: FSM state encoding, decoder enable triple and a small sizing helper.
// Ports: none (package).
package demux_strobe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Decoder enables: one active-high, two active-low (always driven together).
  typedef struct packed {
    logic g1;
    logic g2a_n;
    logic g2b_n;
  } dec_en_t;

  localparam dec_en_t EN_OFF = '{g1: 1'b0, g2a_n: 1'b1, g2b_n: 1'b1};
  localparam dec_en_t EN_ON  = '{g1: 1'b1, g2a_n: 1'b0, g2b_n: 1'b0};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/demux_strobe_rr_arbiter.sv
// rtl/demux_strobe_rr_arbiter.sv - combinational round-robin arbiter with request mask
// Purpose: picks the first eligible requester searching upward from ptr, wrapping.
// Ports:
//   req      in   NREQ  raw requests
//   mask     in   NREQ  requesters excluded from this pick
//   ptr      in   PW    search start index
//   win      out  NREQ  one-hot winner
//   win_idx  out  PW    binary index of winner
//   valid    out  1     a winner exists
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx,
  output logic            valid
);

  logic [NREQ-1:0] eligible;
  int              cand;

  assign eligible = req & ~mask;

  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!valid && eligible[cand]) begin
        valid       = 1'b1;
        win[cand]   = 1'b1;
        win_idx     = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/demux_strobe_arbiter.sv
// rtl/demux_strobe_arbiter.sv - glitch-free sequencer sharing one 3-to-8 decoder
// Purpose: grants one requester at a time, drives the decoder address, then
//   opens the enables for a strobe window, then holds the address after closing.
// Ports:
//   clk        in   1       system clock
//   reset      in   1       asynchronous active-high reset
//   req        in   NREQ    per-requester request
//   sel        in   3*NREQ  per-requester decoder line
//   gnt        out  NREQ    one-hot grant for the whole transaction
//   done       out  NREQ    one-cycle completion pulse
//   dec_a      out  3       decoder address
//   dec_g1     out  1       decoder active-high enable
//   dec_g2a_n  out  1       decoder active-low enable
//   dec_g2b_n  out  1       decoder active-low enable
//   busy       out  1       transaction in progress
module demux_strobe_arbiter
  import demux_strobe_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] sel,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2:0]        dec_a,
  output logic              dec_g1,
  output logic              dec_g2a_n,
  output logic              dec_g2b_n,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(max3(SETUP, STROBE, HOLD)) + 1;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [PW-1:0]   ptr;
  dec_en_t         en;
  logic [NREQ-1:0] arb_mask, arb_win;
  logic [PW-1:0]   arb_idx;
  logic            arb_valid;
  logic            take;

  // Leaving HOLD must not re-grant the requester that just finished.
  assign arb_mask = (state == ST_HOLD) ? gnt : '0;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req),
    .mask    (arb_mask),
    .ptr     (ptr),
    .win     (arb_win),
    .win_idx (arb_idx),
    .valid   (arb_valid)
  );

  // cnt holds remaining cycles minus one; phase ends when it reaches zero.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    case (state)
      ST_IDLE: take = arb_valid;
      ST_SETUP:
        if (cnt == '0) begin
          state_nx = ST_STROBE;
          cnt_nx   = CW'(STROBE - 1);
        end else cnt_nx = cnt - 1'b1;
      ST_STROBE:
        if (cnt == '0) begin
          state_nx = ST_HOLD;
          cnt_nx   = CW'(HOLD - 1);
        end else cnt_nx = cnt - 1'b1;
      ST_HOLD:
        if (cnt == '0) begin
          if (arb_valid) take = 1'b1;
          else state_nx = ST_IDLE;
        end else cnt_nx = cnt - 1'b1;
      default: state_nx = ST_IDLE;
    endcase
    if (take) begin
      state_nx = ST_SETUP;
      cnt_nx   = CW'(SETUP - 1);
    end
  end

  // Outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      done  <= '0;
      dec_a <= '0;
      en    <= EN_OFF;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= (state_nx != ST_IDLE);
      en    <= (state_nx == ST_STROBE) ? EN_ON : EN_OFF;
      done  <= (state_nx == ST_HOLD && cnt_nx == '0) ? gnt : '0;
      if (take) begin
        gnt   <= arb_win;
        dec_a <= sel[3*int'(arb_idx) +: 3];
        ptr   <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
      end else if (state_nx == ST_IDLE) begin
        gnt <= '0;
      end
    end
  end

  assign dec_g1    = en.g1;
  assign dec_g2a_n = en.g2a_n;
  assign dec_g2b_n = en.g2b_n;

endmodule

// File: tb/tb_demux_strobe_arbiter.sv
// tb/tb_demux_strobe_arbiter.sv - self-checking bench for demux_strobe_arbiter
module tb_demux_strobe_arbiter;

  localparam int N  = 4;
  localparam int S  = 1;
  localparam int ST = 2;
  localparam int H  = 1;
  localparam int T  = S + ST + H;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]   req_a = '0, gnt_a, done_a;
  logic [3*N-1:0] sel_a = '0;
  logic [2:0]     deca_a;
  logic           g1_a, g2a_a, g2b_a, busy_a;

  logic [N-1:0]   req_b = '0, gnt_b, done_b;
  logic [3*N-1:0] sel_b = '0;
  logic [2:0]     deca_b;
  logic           g1_b, g2a_b, g2b_b, busy_b;

  int errors = 0;
  int checks = 0;

  // transaction-level reference model for dut_a
  bit         m_active;
  int         m_pos, m_win, m_ptr;
  logic [2:0] m_addr;
  logic [N-1:0] e_gnt, e_done, prev_done, hold_mask;
  logic       e_en, e_busy;

  demux_strobe_arbiter #(.NREQ(N), .SETUP(S), .STROBE(ST), .HOLD(H)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .sel(sel_a), .gnt(gnt_a), .done(done_a),
    .dec_a(deca_a), .dec_g1(g1_a), .dec_g2a_n(g2a_a), .dec_g2b_n(g2b_a), .busy(busy_a));

  demux_strobe_arbiter #(.NREQ(N), .SETUP(3), .STROBE(1), .HOLD(2)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .sel(sel_b), .gnt(gnt_b), .done(done_b),
    .dec_a(deca_b), .dec_g1(g1_b), .dec_g2a_n(g2a_b), .dec_g2b_n(g2b_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic model_outputs();
    e_gnt  = '0;
    e_done = '0;
    if (m_active) e_gnt[m_win] = 1'b1;
    if (m_active && m_pos == T) e_done[m_win] = 1'b1;
    e_en   = m_active && (m_pos > S) && (m_pos <= S + ST);
    e_busy = m_active;
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_pos     = 0;
    m_win     = 0;
    m_ptr     = 0;
    m_addr    = '0;
    prev_done = '0;
    model_outputs();
  endtask

  // One clock edge: a finished (or absent) transaction lets the next requester in,
  // searching from the rotating pointer and skipping the one just served.
  task automatic model_edge();
    bit ending;
    int w;
    int c;
    ending = m_active && (m_pos == T);
    if (!m_active || ending) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && req_a[c] && !(ending && c == m_win)) w = c;
      end
      if (w >= 0) begin
        m_active = 1'b1;
        m_pos    = 1;
        m_win    = w;
        m_addr   = sel_a[3*w +: 3];
        m_ptr    = (w + 1) % N;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_pos++;
    end
    model_outputs();
  endtask

  // Advance one cycle; requesters drop req the cycle after their done unless held.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_edge();
    req_a     = req_a & ~(prev_done & ~hold_mask);
    prev_done = e_done;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt_a); end
    checks++; if (done_a !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done_a); end
    checks++; if (deca_a !== 3'd0) begin errors++; $display("FAIL reset_dec_a: got %0d want 0", deca_a); end
    checks++; if ({g1_a, g2a_a, g2b_a} !== 3'b011) begin errors++; $display("FAIL reset_en: got %b want 011", {g1_a, g2a_a, g2b_a}); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", busy_a, busy_b); end
    model_reset();
    hold_mask = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    sel_a      = '0;
    sel_a[8:6] = 3'd5;
    req_a      = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (gnt_a !== ((c <= 4) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_gnt t%0d: got %b", c, gnt_a); end
      checks++; if (g1_a !== (c == 2 || c == 3)) begin errors++; $display("FAIL single_g1 t%0d: got %b", c, g1_a); end
      checks++; if (g2a_a !== !(c == 2 || c == 3)) begin errors++; $display("FAIL single_g2a t%0d: got %b", c, g2a_a); end
      checks++; if (done_a !== ((c == 4) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_done t%0d: got %b", c, done_a); end
      checks++; if (busy_a !== (c <= 4)) begin errors++; $display("FAIL single_busy t%0d: got %b", c, busy_a); end
      checks++; if (deca_a !== 3'd5) begin errors++; $display("FAIL single_dec_a t%0d: got %0d want 5", c, deca_a); end
    end
  endtask

  task automatic test_contention();
    logic [2:0] pa;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) sel_a[3*i +: 3] = 3'(i);
    req_a = 4'b1111;
    pa = deca_a;
    for (int k = 1; k <= 4 * T; k++) begin
      tick();
      checks++; if (gnt_a !== e_gnt || gnt_a !== (4'b0001 << ((k - 1) / T))) begin errors++; $display("FAIL contention_gnt c%0d: got %b", k, gnt_a); end
      checks++; if (deca_a !== 3'((k - 1) / T)) begin errors++; $display("FAIL contention_dec_a c%0d: got %0d want %0d", k, deca_a, (k - 1) / T); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL contention_gap c%0d: busy %b want 1", k, busy_a); end
      checks++; if (g1_a && deca_a !== pa) begin errors++; $display("FAIL contention_glitch c%0d: dec_a %0d moved from %0d under enable", k, deca_a, pa); end
      pa = deca_a;
    end
    tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL contention_idle: busy %b want 0", busy_a); end
  endtask

  task automatic test_fairness();
    int exp_i;
    hold_mask = 4'b1001;
    req_a     = 4'b1001;
    for (int k = 1; k <= 4 * T; k++) begin
      tick();
      if ((k - 1) % T == 0) begin
        exp_i = (((k - 1) / T) % 2 == 0) ? 0 : 3;
        checks++; if (gnt_a !== (4'b0001 << exp_i)) begin errors++; $display("FAIL fairness_gnt txn%0d: got %b want idx %0d", (k - 1) / T, gnt_a, exp_i); end
        checks++; if (gnt_a !== e_gnt) begin errors++; $display("FAIL fairness_model txn%0d: got %b want %b", (k - 1) / T, gnt_a, e_gnt); end
      end
    end
    hold_mask = '0;
    req_a     = '0;
    for (int k = 0; k < 2 * T; k++) tick();
  endtask

  task automatic test_reset_mid_strobe();
    sel_a[8:6] = 3'd6;
    req_a      = 4'b0100;
    tick();
    tick();
    checks++; if (g1_a !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: g1 %b want 1", g1_a); end
    #2 reset = 1'b1;
    #1;
    checks++; if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_async: gnt %b busy %b want 0000 0", gnt_a, busy_a); end
    checks++; if ({g1_a, g2a_a, g2b_a} !== 3'b011 || deca_a !== 3'd0) begin errors++; $display("FAIL rst_mid_dec: en %b a %0d want 011 0", {g1_a, g2a_a, g2b_a}, deca_a); end
    model_reset();
    sel_a[5:3]  = 3'd3;
    sel_a[11:9] = 3'd7;
    req_a       = 4'b1010;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL rst_mid_regrant: got %b want 0010", gnt_a); end
    checks++; if (deca_a !== 3'd3) begin errors++; $display("FAIL rst_mid_addr: got %0d want 3", deca_a); end
    for (int k = 0; k < 3 * T; k++) begin
      tick();
      checks++; if (done_a[2] !== 1'b0 || done_a !== e_done) begin errors++; $display("FAIL rst_mid_done c%0d: got %b want %b", k, done_a, e_done); end
    end
    req_a = '0;
    for (int k = 0; k < T + 1; k++) tick();
  endtask

  task automatic test_params_b();
    sel_b[5:3] = 3'd4;
    req_b      = 4'b0010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++; if (g1_b !== (c == 4) || g2b_b !== (c != 4)) begin errors++; $display("FAIL param_en t%0d: g1 %b g2b %b", c, g1_b, g2b_b); end
      checks++; if (done_b !== ((c == 6) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL param_done t%0d: got %b", c, done_b); end
      checks++; if (gnt_b !== ((c <= 6) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL param_gnt t%0d: got %b", c, gnt_b); end
      if (c <= 6) begin
        checks++; if (deca_b !== 3'd4) begin errors++; $display("FAIL param_dec_a t%0d: got %0d want 4", c, deca_b); end
      end
      if (c == 7) req_b = '0;
    end
  endtask

  task automatic test_random();
    int viol, last_chg, last_en;
    logic [2:0] pa;
    viol     = 0;
    last_chg = -100;
    last_en  = -100;
    pa       = deca_a;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_a[i]) begin
          if ($urandom % 4 == 0) begin
            req_a[i]        = 1'b1;
            sel_a[3*i +: 3] = 3'($urandom);
          end
        end else if (m_active && m_win == i && $urandom % 64 == 0) begin
          if ($urandom % 2 == 0) req_a[i] = 1'b0;
          else sel_a[3*i +: 3] = 3'($urandom);
        end
      end
      tick();
      checks++; if (gnt_a !== e_gnt) begin errors++; $display("FAIL rand_gnt c%0d: got %b want %b", k, gnt_a, e_gnt); end
      checks++; if (done_a !== e_done) begin errors++; $display("FAIL rand_done c%0d: got %b want %b", k, done_a, e_done); end
      checks++; if (deca_a !== m_addr) begin errors++; $display("FAIL rand_dec_a c%0d: got %0d want %0d", k, deca_a, m_addr); end
      checks++; if ({g1_a, g2a_a, g2b_a} !== {e_en, !e_en, !e_en}) begin errors++; $display("FAIL rand_en c%0d: got %b want en=%b", k, {g1_a, g2a_a, g2b_a}, e_en); end
      checks++; if (busy_a !== e_busy) begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", k, busy_a, e_busy); end
      if (deca_a !== pa) begin
        if (k - last_en <= H) viol++;
        last_chg = k;
      end
      if (g1_a || !g2a_a || !g2b_a) begin
        if (k - last_chg < S) viol++;
        last_en = k;
      end
      pa = deca_a;
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL glitch_violations: got %0d want 0", viol); end
  endtask

  initial begin
    hold_mask = '0;
    prev_done = '0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_reset_mid_strobe();
    test_params_b();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_strobe_arbiter.md
# demux_strobe_arbiter

Clocked controller that shares one 74x138-style 3-to-8 decoder between several requesters and sequences its inputs so that no select output ever glitches. Each transaction drives the decoder address first, asserts the enables for a programmable strobe window, then holds the address while the enables are removed. This avoids unequal enable-path delays producing spurious low pulses on unit-select lines. It sits between bus-cycle initiators (microcode sequencer, DMA, front panel) and the decoder that generates active-low unit strobes.

## Interface
- NREQ, 4: number of requesters (2..8).
- SETUP, 1: cycles the address is stable before enable (>=1).
- STROBE, 2: cycles the enables are asserted (>=1).
- HOLD, 1: cycles the address is held after enable removal (>=1).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held high until that requester's done pulse.
- sel  in  3*NREQ  target decoder line; requester i uses sel[3*i+2:3*i]; stable while req[i] is high.
- gnt  out  NREQ  one-hot grant; high for the whole transaction.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- dec_a  out  3  decoder address input.
- dec_g1  out  1  decoder active-high enable.
- dec_g2a_n, dec_g2b_n  out  1 each  decoder active-low enables; always driven identically.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Reset values: dec_a=0, dec_g1=0, dec_g2a_n=1, dec_g2b_n=1, gnt=0, done=0, busy=0, round-robin pointer=0, state=IDLE.
- States: IDLE, SETUP, STROBE, HOLD. One phase counter, width clog2(max(SETUP,STROBE,HOLD))+1, loaded on each state entry.
- IDLE: if any req is high, pick a winner round-robin, starting the search at the pointer. Latch its sel into dec_a, set gnt, go to SETUP. The pointer becomes winner+1 mod NREQ.
- SETUP: enables deasserted, dec_a stable. After SETUP cycles, go to STROBE.
- STROBE: dec_g1=1, dec_g2a_n=dec_g2b_n=0. dec_a is unchanged. After STROBE cycles, go to HOLD.
- HOLD: enables deasserted, dec_a unchanged. done[winner]=1 in the final HOLD cycle only.
  - At exit, arbitrate again with the current winner masked out.
  - If any other req is high, go directly to SETUP with the new grant; otherwise go to IDLE.
- A requester must drop req in the cycle after done. If it is still high then, that is a new request.
- If req falls mid-transaction, the transaction still runs to completion with no abort. done still pulses.
- Enables and dec_a never change in the same cycle. dec_a changes only on entry to SETUP.
- Reset mid-transaction forces reset values immediately. No done is issued for the aborted transaction.
- sel changing while granted is ignored, because the latched dec_a is used.

## Timing
- All outputs are registered. No combinational path from req or sel to any output.
- With req[i] high at IDLE edge t:
  - gnt and dec_a valid from t+1.
  - Enables active for cycles t+1+SETUP through t+SETUP+STROBE.
  - done during cycle t+SETUP+STROBE+HOLD.
- Transaction length is SETUP+STROBE+HOLD cycles (defaults: 4).
- Back-to-back transactions have no idle cycle between them.
- Throughput with continuous contention: one transaction per SETUP+STROBE+HOLD cycles. No requester waits more than NREQ-1 transactions.

## Structure
- Package demux_strobe_pkg holds:
  - state encoding constants (IDLE=0, SETUP=1, STROBE=2, HOLD=3);
  - the disabled-enable constant triple (g1=0, g2a_n=1, g2b_n=1).
- Sub-module rr_arbiter(NREQ) is combinational and takes req, mask and pointer.
  - It returns a one-hot winner and a valid flag.
  - It is instantiated once; the FSM owns the pointer register.

## Test plan
- Single request, defaults: req[2]=1, sel[8:6]=5 at t0 → gnt=0100 at t1; dec_a=5 at t1; enables active in t2–t3; done[2] in t4; state returns to IDLE at t5.
- Contention: req=1111 with sels 0,1,2,3 held → grants in order 0,1,2,3 with no idle gaps. dec_a never changes while dec_g1=1.
- Fairness: req[0] continuously re-asserted and req[3]=1 → grants alternate 0,3,0,3.
- Glitch check: a checker flags any cycle where dec_a changes while enables are active, or within SETUP/HOLD of activation → zero violations over 10k random req/sel cycles.
- Reset mid-STROBE: assert reset asynchronously → outputs go to reset values before the next edge. After release, a pending req is re-granted from pointer 0.
- Parameters SETUP=3, STROBE=1, HOLD=2: req[1] at t0 → enable active only in t4; done[1] in t6.
